// File: rtl/gf163_pkg.sv
// Shared definitions for the GF(2^163) datapath.
// Field polynomial f(x) = x^163 + x^7 + x^6 + x^3 + 1.
//   M        : field degree / reduced width
//   D        : digit width of the serial multiplier
//   NDIG     : digits per operand (operand b zero-padded to NDIG*D bits)
//   PPW      : width of one unreduced a(x)*b_i(x) partial product
//   RED_TAPS : low-order terms of f(x), used to fold x^163 back into the field
package gf163_pkg;

  localparam int unsigned M     = 163;
  localparam int unsigned D     = 16;
  localparam int unsigned NDIG  = 11;
  localparam int unsigned PPW   = M + D - 1;
  localparam int unsigned CNT_W = 4;

  localparam int unsigned NTAPS = 4;
  localparam int unsigned RED_TAPS [NTAPS] = '{7, 6, 3, 0};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/gf163_fold16.sv
// Single-pass reduction of a (M+D)-bit polynomial into GF(2^163).
// The D bits above degree M-1 are folded back through the low terms of f(x).
// With D=16 the highest folded degree is 15+7=22, so one pass fully reduces.
//   t : unreduced polynomial, degrees M+D-1..0
//   r : t mod f(x), degrees M-1..0
module gf163_fold16
  import gf163_pkg::*;
(
  input  logic [M+D-1:0] t,
  output logic [M-1:0]   r
);

  logic [D-1:0] h;

  assign h = t[M+D-1:M];

  always_comb begin
    r = t[M-1:0];
    for (int unsigned i = 0; i < NTAPS; i++) begin
      r = r ^ (M'(h) << RED_TAPS[i]);
    end
  end

endmodule

// File: rtl/gf163_digit_accum.sv
// MSB-first digit-serial accumulate-and-reduce stage of a GF(2^163) multiplier.
// Each accepted beat computes acc <= ((acc << D) ^ pp) mod f. After NDIG
// beats the reduced product is offered on a valid/ready result port.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : begin a new product (ignored unless idle)
//   busy                : product in progress or result pending
//   dig_idx             : b digit index the upstream must supply (10 down to 0)
//   pp_valid / pp_ready : partial-product handshake, pp_data unreduced a*b_i
//   res_valid/ res_ready: result handshake, res_data = a*b mod f
module gf163_digit_accum
  import gf163_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic [CNT_W-1:0] dig_idx,
  input  logic             pp_valid,
  output logic             pp_ready,
  input  logic [PPW-1:0]   pp_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [M-1:0]     res_data
);

  state_e           state_q, state_d;
  logic [M-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [M+D-1:0]   fold_t;
  logic [M-1:0]     fold_r;

  // pp_data is one bit narrower than the shifted accumulator; top bit is 0.
  assign fold_t = {acc_q, {D{1'b0}}} ^ {1'b0, pp_data};

  gf163_fold16 u_fold (
    .t (fold_t),
    .r (fold_r)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          cnt_d   = CNT_W'(NDIG - 1);
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (pp_valid) begin
          acc_d = fold_r;
          if (cnt_q == '0) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode registered state only: no path from pp_valid or res_ready.
  always_comb begin
    busy      = 1'b0;
    pp_ready  = 1'b0;
    res_valid = 1'b0;
    dig_idx   = '0;
    res_data  = '0;
    unique case (state_q)
      IDLE: begin
      end
      ACCUM: begin
        busy     = 1'b1;
        pp_ready = 1'b1;
        dig_idx  = cnt_q;
      end
      DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        res_data  = acc_q;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: doc/gf163_digit_accum.md
Name: gf163_digit_accum

Overview:
- Digit-serial accumulate-and-reduce stage for GF(2^163) multiplication, field polynomial f(x) = x^163 + x^7 + x^6 + x^3 + 1.
- Sits directly downstream of the 163x16 partial-product combiner. It consumes one 178-bit partial product a(x)*b_i(x) per beat and drives the digit index for the next beat.
- Operates MSB-first: acc <= ((acc << 16) ^ pp) mod f.
- After 11 beats it presents the fully reduced 163-bit product a*b mod f on a valid/ready result port.

Parameters:
- M, 163, field degree / result width
- D, 16, digit width
- NDIG, 11, digits per operand = ceil(M/D); operand b is zero-padded to 176 bits
- PPW, 178, partial-product width = M+D-1

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a new product; honoured only in IDLE
- busy  out  1  high in ACCUM and DONE
- dig_idx  out  4  index of the b digit the upstream must supply on the current beat (10 down to 0)
- pp_valid  in  1  partial product present
- pp_ready  out  1  stage accepts pp_data
- pp_data  in  178  a(x)*b_dig_idx(x), unreduced
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  163  reduced product

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, rst_n. While rst_n=0, and immediately on its assertion, all of the following hold: state=IDLE, acc=0, cnt=0, busy=0, pp_ready=0, res_valid=0, res_data=0, dig_idx=0.
- FSM states are IDLE, ACCUM and DONE.
- IDLE:
  - pp_ready=0, res_valid=0.
  - On start=1: acc<=0, cnt<=NDIG-1 (10), next state ACCUM.
- ACCUM:
  - pp_ready=1, dig_idx=cnt.
  - A beat is accepted when pp_valid & pp_ready.
  - On each accepted beat, t = {acc,16'b0} ^ zero-extend(pp_data). t is 179 bits, bits 178..0.
  - Fold: h = t[178:163] (16 bits). acc <= t[162:0] ^ h ^ (h<<3) ^ (h<<6) ^ (h<<7). The highest resulting degree is 22, so a single fold fully reduces; no second pass.
  - If cnt==0 on the accepted beat, next state is DONE. Otherwise cnt<=cnt-1.
  - With pp_valid=0, hold all state.
- DONE:
  - res_valid=1, res_data=acc, pp_ready=0.
  - res_data is held stable while res_ready=0.
  - On res_valid & res_ready, next state is IDLE. res_valid drops the following cycle.
- Latency and throughput:
  - res_valid rises the cycle after the 11th accepted beat.
  - Minimum start-to-result time is 12 cycles: 1 start cycle plus 11 beats at full rate.
  - Throughput is one digit per cycle.
- Boundary conditions:
  - start while busy is ignored. There is no restart and no error flag.
  - start in the same cycle as the DONE handshake is ignored. The block returns to IDLE first.
  - pp_data bits are used as-is. Upstream guarantees the final digit covers only b[162:160] (top 13 bits zero). Stray high bits are folded like any others, not masked.
  - pp_ready is registered state, not combinational from pp_valid. There is no combinational path from pp_valid to pp_ready or from res_ready to res_valid.
  - Reset mid-operation discards the partial accumulation. No result is produced.

Decomposition:
- Shared package gf163_pkg holds:
  - constants M, D, NDIG, PPW
  - the reduction tap list {7,6,3,0}
  - a 2-bit state typedef (IDLE/ACCUM/DONE)
- One natural sub-module: gf163_fold16. It is purely combinational: 179-bit t in, 163-bit reduced value out, implementing the h-fold above. It is reused by later squaring stages.
- FSM, counter and handshakes stay in gf163_digit_accum.

Test Plan:
- Identity: start, 11 beats where beats 1-10 have pp=0 and beat 11 has pp=1 -> res_data=1, res_valid 1 cycle after beat 11, dig_idx sequence 10,9,...,0.
- Reduction: a=x^162, b=x, so only beat 11 carries pp=bit163 set -> res_data=0xC9 (x^7+x^6+x^3+1).
- Shift path: beat 1 (idx 10) pp=1, others 0 -> res_data = x^160 mod f = bit160 set only, no fold. Beat 10 (idx 1) pp=bit162, others 0 -> bit178 -> x^15*(x^7+x^6+x^3+1) = bits 22,21,18,15.
- Flow control: pp_valid deasserted on alternating cycles -> same result as the full-rate run, cnt and acc frozen on idle cycles. res_ready low for 5 cycles -> res_data and res_valid stable; start pulses in ACCUM/DONE are ignored.
- Reset mid-op: drive rst_n low after 5 accepted beats -> all outputs 0 asynchronously. After release, a fresh start plus the identity sequence gives res_data=1.
- Randomised: 1000 random a,b with a golden model carry-less multiply mod f; upstream model supplies a*b_i. Compare res_data under random pp_valid/res_ready stalls.
